// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: op encoding, flag bit
// positions, controller FSM states and default latencies.
package fpu_ctrl_pkg;

    // Operation codes carried on reqN_op / fpu_op
    typedef enum logic [2:0] {
        FOP_ADD  = 3'd0,
        FOP_SUB  = 3'd1,
        FOP_MUL  = 3'd2,
        FOP_DIV  = 3'd3,
        FOP_SQRT = 3'd4,
        FOP_CMP  = 3'd5,
        FOP_I2F  = 3'd6,
        FOP_F2I  = 3'd7
    } fpu_op_e;

    // Bit positions inside the 3-bit {NV, INF, QN} flag vectors
    localparam int unsigned FLAG_NV  = 2;
    localparam int unsigned FLAG_INF = 1;
    localparam int unsigned FLAG_QN  = 0;

    // Default datapath / classifier latencies
    localparam int LAT_DEFAULT     = 4;
    localparam int EXC_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } issue_state_e;

    // Fold the raw classifier outputs into the {NV, INF, QN} flag vector
    function automatic logic [2:0] classify_flags(
        input logic inf,
        input logic ind,
        input logic qnan,
        input logic snan
    );
        logic [2:0] f;
        f           = '0;
        f[FLAG_NV]  = snan | ind;
        f[FLAG_INF] = inf;
        f[FLAG_QN]  = qnan;
        return f;
    endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// Two-way round-robin arbiter. Grant is combinational; the pointer only
// moves when a grant is actually given.
module fpu_rr_arb
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

    // 1 means requester 1 was granted most recently
    logic last_grant;

    // Grant selection: a lone requester always wins, contention alternates
    always_comb begin
        grant = '0;
        if (en) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    // Pointer register; reset value lets requester 0 win first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for a fixed-latency FPU shared by two requesters:
// round-robin issue, in-flight tracking, per-op flag staging, sticky
// flag accumulation and a drain handshake.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT     = LAT_DEFAULT,
    parameter int EXC_LAT = EXC_LAT_DEFAULT
)
(
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_opa,
    input  logic [31:0] req0_opb,
    input  logic [2:0]  req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_opa,
    input  logic [31:0] req1_opb,
    input  logic [2:0]  req1_op,

    output logic        fpu_valid,
    output logic [31:0] fpu_opa,
    output logic [31:0] fpu_opb,
    output logic [2:0]  fpu_op,
    input  logic [31:0] fpu_res,
    input  logic        exc_inf,
    input  logic        exc_ind,
    input  logic        exc_qnan,
    input  logic        exc_snan,

    output logic        resp0_valid,
    output logic [31:0] resp0_res,
    output logic [2:0]  resp0_flags,
    output logic        resp1_valid,
    output logic [31:0] resp1_res,
    output logic [2:0]  resp1_flags,

    output logic [2:0]  sticky0,
    input  logic        clr0,
    output logic [2:0]  sticky1,
    input  logic        clr1,

    input  logic        drain_req,
    output logic        drain_done,
    output logic        busy
);

    issue_state_e          state;
    issue_state_e          state_nxt;
    logic                  done_seen;

    logic                  arb_en;
    logic [1:0]            grant;
    logic                  issue;

    // Stage k of each pipe holds the op issued k cycles ago
    logic [LAT:1]          v_pipe;
    logic [LAT:1]          id_pipe;
    logic [LAT:1][2:0]     flag_pipe;

    logic                  pipe_empty;
    logic [2:0]            cap_flags;
    logic [2:0]            stage_flags;
    logic                  resp_v;
    logic                  resp_id;

    assign pipe_empty = ~|v_pipe;

    // Grants are withheld while draining, while a drain is being requested,
    // and while reset is held so every output is quiet during reset
    assign arb_en = !rst && !drain_req && (state != ST_DRAIN);

    fpu_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req_valid ({req1_valid, req0_valid}),
        .grant     (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign issue      = |grant;

    // Issue port: pass the granted request through, zeros otherwise
    always_comb begin
        fpu_valid = issue;
        fpu_opa   = '0;
        fpu_opb   = '0;
        fpu_op    = '0;
        if (grant[0]) begin
            fpu_opa = req0_opa;
            fpu_opb = req0_opb;
            fpu_op  = req0_op;
        end else if (grant[1]) begin
            fpu_opa = req1_opa;
            fpu_opb = req1_opb;
            fpu_op  = req1_op;
        end
    end

    // Classifier flags only belong to an op if one is at the capture stage
    assign cap_flags = classify_flags(exc_inf, exc_ind, exc_qnan, exc_snan)
                       & {3{v_pipe[EXC_LAT]}};

    // When the classifier and datapath latencies coincide the live flags
    // are used directly at the response stage
    assign stage_flags = (EXC_LAT == LAT) ? cap_flags : flag_pipe[LAT];

    // In-flight valid/id shift pipe and flag staging pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_pipe    <= '0;
            id_pipe   <= '0;
            flag_pipe <= '0;
        end else begin
            v_pipe       <= {v_pipe[LAT-1:1], issue};
            id_pipe      <= {id_pipe[LAT-1:1], grant[1]};
            flag_pipe[1] <= '0;
            for (int unsigned k = 1; k < unsigned'(LAT); k++) begin
                flag_pipe[k+1] <= (k == unsigned'(EXC_LAT)) ? cap_flags
                                                             : flag_pipe[k];
            end
        end
    end

    assign resp_v  = v_pipe[LAT];
    assign resp_id = id_pipe[LAT];

    // Response steering to the owning requester
    always_comb begin
        resp0_valid = resp_v && !resp_id;
        resp1_valid = resp_v &&  resp_id;
        resp0_res   = resp0_valid ? fpu_res     : '0;
        resp1_res   = resp1_valid ? fpu_res     : '0;
        resp0_flags = resp0_valid ? stage_flags : '0;
        resp1_flags = resp1_valid ? stage_flags : '0;
    end

    // Sticky flag accumulation; a coinciding clear keeps the new flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky0 <= '0;
            sticky1 <= '0;
        end else begin
            sticky0 <= (clr0 ? 3'b000 : sticky0) | resp0_flags;
            sticky1 <= (clr1 ? 3'b000 : sticky1) | resp1_flags;
        end
    end

    // FSM state register plus the one-shot memory for drain_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            done_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_seen <= (state_nxt == ST_DRAIN) && (done_seen || drain_done);
        end
    end

    // FSM next-state and drain_done decode
    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (drain_req) begin
                    state_nxt = ST_DRAIN;
                end else if (issue) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (drain_req) begin
                    state_nxt = ST_DRAIN;
                end else if (pipe_empty && !req0_valid && !req1_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // done_seen keeps the pulse single while drain_req stays high
                drain_done = pipe_empty && !done_seen;
                if (drain_done || done_seen) begin
                    state_nxt = drain_req ? ST_DRAIN : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = !pipe_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with LAT=4, EXC_LAT=2.
// Inputs change 1ns after the rising edge, outputs are checked 3ns after.
module tb_fpu_issue_ctrl;

    localparam int LAT     = 4;
    localparam int EXC_LAT = 2;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_opa, req0_opb, req1_opa, req1_opb;
    logic [2:0]  req0_op, req1_op;
    logic        fpu_valid;
    logic [31:0] fpu_opa, fpu_opb;
    logic [2:0]  fpu_op;
    logic [31:0] fpu_res;
    logic        exc_inf, exc_ind, exc_qnan, exc_snan;
    logic        resp0_valid, resp1_valid;
    logic [31:0] resp0_res, resp1_res;
    logic [2:0]  resp0_flags, resp1_flags;
    logic [2:0]  sticky0, sticky1;
    logic        clr0, clr1;
    logic        drain_req, drain_done, busy;

    int n_checks;
    int n_fail;

    fpu_issue_ctrl #(
        .LAT     (LAT),
        .EXC_LAT (EXC_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opa    (req0_opa),
        .req0_opb    (req0_opb),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opa    (req1_opa),
        .req1_opb    (req1_opb),
        .req1_op     (req1_op),
        .fpu_valid   (fpu_valid),
        .fpu_opa     (fpu_opa),
        .fpu_opb     (fpu_opb),
        .fpu_op      (fpu_op),
        .fpu_res     (fpu_res),
        .exc_inf     (exc_inf),
        .exc_ind     (exc_ind),
        .exc_qnan    (exc_qnan),
        .exc_snan    (exc_snan),
        .resp0_valid (resp0_valid),
        .resp0_res   (resp0_res),
        .resp0_flags (resp0_flags),
        .resp1_valid (resp1_valid),
        .resp1_res   (resp1_res),
        .resp1_flags (resp1_flags),
        .sticky0     (sticky0),
        .clr0        (clr0),
        .sticky1     (sticky1),
        .clr1        (clr1),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_opa = '0; req0_opb = '0; req0_op = '0;
        req1_valid = 1'b0; req1_opa = '0; req1_opb = '0; req1_op = '0;
        fpu_res    = '0;
        exc_inf    = 1'b0; exc_ind = 1'b0; exc_qnan = 1'b0; exc_snan = 1'b0;
        clr0       = 1'b0; clr1 = 1'b0;
        drain_req  = 1'b0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        clear_inputs();

        // Reset state: even a valid request sees no grant
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req0_opa   = 32'h0000_1234;
        #2;
        chk("rst_ready0",     req0_ready,  0);
        chk("rst_fpu_valid",  fpu_valid,   0);
        chk("rst_fpu_opa",    fpu_opa,     0);
        chk("rst_busy",       busy,        0);
        chk("rst_sticky0",    sticky0,     0);
        chk("rst_sticky1",    sticky1,     0);
        chk("rst_drain_done", drain_done,  0);
        chk("rst_resp0",      resp0_valid, 0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op from requester 0
        for (int c = 0; c <= 6; c++) begin
            next_cyc();
            req0_valid = (c == 0);
            req0_opa   = 32'h3F80_0000;
            req0_opb   = 32'h4000_0000;
            req0_op    = 3'd2;
            fpu_res    = (c == 4) ? 32'h4040_0000 : (32'hDEAD_0000 | c);
            #2;
            if (c == 0) begin
                chk("t1_ready0", req0_ready, 1);
                chk("t1_fvalid", fpu_valid,  1);
                chk("t1_opa",    fpu_opa,    32'h3F80_0000);
                chk("t1_opb",    fpu_opb,    32'h4000_0000);
                chk("t1_op",     fpu_op,     3'd2);
            end
            if (c == 1) begin
                chk("t1_fvalid_off", fpu_valid, 0);
                chk("t1_busy",       busy,      1);
            end
            chk($sformatf("t1_r0v_c%0d", c), resp0_valid, (c == 4));
            if (c == 4) begin
                chk("t1_res",   resp0_res,   32'h4040_0000);
                chk("t1_flags", resp0_flags, 3'b000);
                chk("t1_r1v",   resp1_valid, 0);
            end
            if (c == 6) chk("t1_busy_idle", busy, 0);
        end

        // Contention: grants alternate, responses follow in the same order
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            next_cyc();
            req0_valid = (c < 6);
            req1_valid = (c < 6);
            req0_opa   = 32'h1000_0000 | c;
            req1_opa   = 32'h2000_0000 | c;
            fpu_res    = 32'hF000_0000 | c;
            #2;
            if (c < 6) begin
                chk($sformatf("t2_rdy0_c%0d", c), req0_ready, (c % 2 == 0));
                chk($sformatf("t2_rdy1_c%0d", c), req1_ready, (c % 2 == 1));
                chk($sformatf("t2_opa_c%0d", c), fpu_opa,
                    (c % 2 == 0) ? (32'h1000_0000 | c) : (32'h2000_0000 | c));
            end
            if (c >= 4 && c <= 9) begin
                chk($sformatf("t2_r0v_c%0d", c), resp0_valid, ((c - 4) % 2 == 0));
                chk($sformatf("t2_r1v_c%0d", c), resp1_valid, ((c - 4) % 2 == 1));
                if ((c - 4) % 2 == 0) chk($sformatf("t2_r0res_c%0d", c), resp0_res, 32'hF000_0000 | c);
                else                  chk($sformatf("t2_r1res_c%0d", c), resp1_res, 32'hF000_0000 | c);
            end
        end

        // sNaN on requester 1, inf+qnan on requester 0, then clear sticky1
        for (int c = 0; c <= 7; c++) begin
            next_cyc();
            req1_valid = (c == 0);
            req1_opa   = 32'h7FA0_0000;
            req0_valid = (c == 1);
            req0_opa   = 32'h7F80_0000;
            exc_snan   = (c == 2);
            exc_inf    = (c == 3);
            exc_qnan   = (c == 3);
            clr1       = (c == 6);
            fpu_res    = 32'hB000_0000 | c;
            #2;
            if (c == 0) begin
                chk("t3_rdy1", req1_ready, 1);
                chk("t3_opa",  fpu_opa,    32'h7FA0_0000);
            end
            if (c == 4) begin
                chk("t3_r1v",    resp1_valid, 1);
                chk("t3_r1flag", resp1_flags, 3'b100);
                chk("t3_r0v",    resp0_valid, 0);
            end
            if (c == 5) begin
                chk("t3_r0v5",    resp0_valid, 1);
                chk("t3_r0flag",  resp0_flags, 3'b011);
                chk("t3_sticky1", sticky1,     3'b100);
                chk("t3_sticky0", sticky0,     3'b000);
            end
            if (c == 6) begin
                chk("t3_sticky0b", sticky0, 3'b011);
                chk("t3_sticky1b", sticky1, 3'b100);
            end
            if (c == 7) begin
                chk("t3_clr1",    sticky1, 3'b000);
                chk("t3_keep0",   sticky0, 3'b011);
            end
        end

        // Reset in the middle of two in-flight ops discards them
        for (int c = 0; c <= 8; c++) begin
            next_cyc();
            req0_valid = (c == 0);
            req1_valid = (c == 1);
            exc_snan   = (c >= 2 && c <= 5);
            if (c == 2) rst = 1'b1;
            if (c == 3) rst = 1'b0;
            #2;
            if (c >= 2) begin
                chk($sformatf("t4_r0v_c%0d", c), resp0_valid, 0);
                chk($sformatf("t4_r1v_c%0d", c), resp1_valid, 0);
                chk($sformatf("t4_busy_c%0d", c), busy, 0);
            end
            if (c == 8) begin
                chk("t4_sticky0", sticky0, 3'b000);
                chk("t4_sticky1", sticky1, 3'b000);
            end
        end
        clear_inputs();

        // Clear coinciding with an NV response keeps the new NV flag
        for (int c = 0; c <= 7; c++) begin
            next_cyc();
            req0_valid = (c < 2);
            exc_inf    = (c == 2);
            exc_ind    = (c == 3);
            clr0       = (c == 5) || (c == 6);
            #2;
            if (c == 4) chk("t5_flag_inf", resp0_flags, 3'b010);
            if (c == 5) begin
                chk("t5_sticky_inf", sticky0,     3'b010);
                chk("t5_flag_nv",    resp0_flags, 3'b100);
            end
            if (c == 6) chk("t5_set_wins", sticky0, 3'b100);
            if (c == 7) chk("t5_cleared",  sticky0, 3'b000);
        end
        clear_inputs();

        // Drain with three ops in flight, held drain_req, then re-drain empty
        for (int c = 0; c <= 12; c++) begin
            next_cyc();
            req0_valid = (c < 4);
            req0_opa   = 32'hD000_0000 | c;
            drain_req  = (c >= 3 && c <= 8) || (c == 10);
            fpu_res    = 32'hE000_0000 | c;
            #2;
            if (c < 3) chk($sformatf("t6_rdy0_c%0d", c), req0_ready, 1);
            if (c == 3) begin
                chk("t6_rdy0_drain", req0_ready, 0);
                chk("t6_fvalid",     fpu_valid,  0);
            end
            if (c >= 4 && c <= 6) begin
                chk($sformatf("t6_r0v_c%0d", c), resp0_valid, 1);
                chk($sformatf("t6_res_c%0d", c), resp0_res,   32'hE000_0000 | c);
            end
            if (c == 7) chk("t6_r0v_end", resp0_valid, 0);
            if (c >= 3) chk($sformatf("t6_done_c%0d", c), drain_done, (c == 7) || (c == 11));
            if (c == 9)  chk("t6_busy_drain", busy, 1);
            if (c == 10) chk("t6_busy_idle",  busy, 0);
            if (c == 12) chk("t6_busy_end",   busy, 0);
        end
        clear_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
